// File: rtl/ss_seq_pkg.sv
// Shared types and default timing constants for the spread spectrum correlator sequencer.
package ss_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PRE,
      ST_SYNC,
      ST_POST,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int DEF_NREGS      = 16;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_SYNC_PRE   = 2;
   localparam int DEF_SYNC_HI    = 2;
   localparam int DEF_SYNC_POST  = 3;
   localparam int DEF_DRAIN_CYC  = 500;

   typedef logic [23:0] cnt24_t;

endpackage

// File: rtl/ss_seq_if.sv
// Host config bus, upstream sample stream and correlator control bus of the sequencer.
interface ss_seq_if;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        s_valid;
   logic [11:0] s_data;
   logic        s_ready;
   logic [31:0] c_din;
   logic [3:0]  c_addr;
   logic        c_strobe;
   logic [11:0] c_samp;
   logic        c_push_samp;
   logic        c_sync;
   logic        c_push_corr;

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, s_valid, s_data, c_push_corr,
      output s_ready, c_din, c_addr, c_strobe, c_samp, c_push_samp, c_sync
   );

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, s_valid, s_data, c_push_corr,
      input  s_ready, c_din, c_addr, c_strobe, c_samp, c_push_samp, c_sync
   );
endinterface

// File: rtl/ss_samp_fifo.sv
// Small synchronous skid FIFO for upstream samples; head is the oldest entry, no bypass.
module ss_samp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   level_reg;
   logic          push_ok, pop_ok;

   assign full    = (level_reg == (AW+1)'(DEPTH));
   assign empty   = (level_reg == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign head    = mem[rd_ptr_reg];
   assign level   = level_reg;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + (AW+1)'(1);
            2'b01:   level_reg <= level_reg - (AW+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end
endmodule

// File: rtl/ss_seq.sv
// Correlator sequencer: register load, guarded sync burst, sample streaming and drain window.
module ss_seq
   import ss_seq_pkg::*;
#(
   parameter int NREGS      = DEF_NREGS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int SYNC_PRE   = DEF_SYNC_PRE,
   parameter int SYNC_HI    = DEF_SYNC_HI,
   parameter int SYNC_POST  = DEF_SYNC_POST,
   parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     start,
   input  logic     abort,
   input  cnt24_t   nsamp,
   output logic     busy,
   output logic     done,
   output cnt24_t   corr_cnt,
   ss_seq_if.slave  bus
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   state_t        state_reg, state_next;
   logic [15:0]   cnt_reg, cnt_next;
   cnt24_t        nsamp_reg, nsamp_next, acc_reg, acc_next;
   cnt24_t        pushed_reg, pushed_next, corr_reg, corr_next;
   logic [31:0]   bank_reg [NREGS];
   logic          bank_we, xfer, load_en;
   logic [3:0]    load_idx;
   logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [11:0]   fifo_head;
   logic [LW-1:0] fifo_level, level_next;

   logic          s_ready_reg, s_ready_next, c_strobe_reg, c_strobe_next;
   logic          c_push_samp_reg, c_push_samp_next, c_sync_reg, c_sync_next;
   logic          busy_reg, busy_next, done_reg, done_next;
   logic [31:0]   c_din_reg, c_din_next;
   logic [3:0]    c_addr_reg, c_addr_next;
   logic [11:0]   c_samp_reg, c_samp_next;

   assign bank_we = bus.cfg_we && (state_reg == ST_IDLE);
   assign xfer    = bus.s_valid && s_ready_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) bank_reg[i] <= '0;
      end else if (bank_we) begin
         bank_reg[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   ss_samp_fifo #(.DEPTH(FIFO_DEPTH), .W(12)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (bus.s_data),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      nsamp_next       = nsamp_reg;
      pushed_next      = pushed_reg;
      fifo_flush       = abort;
      fifo_push        = xfer && !fifo_full && !abort;
      fifo_pop         = 1'b0;
      acc_next         = acc_reg + cnt24_t'(fifo_push);
      load_en          = 1'b0;
      load_idx         = '0;
      c_samp_next      = '0;
      c_push_samp_next = 1'b0;
      case (state_reg)
         ST_IDLE: if (start) begin
            state_next  = ST_LOAD;
            cnt_next    = '0;
            nsamp_next  = nsamp;
            acc_next    = '0;
            pushed_next = '0;
            load_en     = 1'b1;
         end
         ST_LOAD: if (cnt_reg == 16'(NREGS - 1)) begin
            state_next = ST_PRE;
            cnt_next   = '0;
         end else begin
            cnt_next = cnt_reg + 16'd1;
            load_en  = 1'b1;
            load_idx = cnt_reg[3:0] + 4'd1;
         end
         ST_PRE: if (cnt_reg == 16'(SYNC_PRE - 1)) begin
            state_next = ST_SYNC;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 16'd1;
         ST_SYNC: if (cnt_reg == 16'(SYNC_HI - 1)) begin
            state_next = ST_POST;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 16'd1;
         ST_POST: if (cnt_reg == 16'(SYNC_POST - 1)) begin
            state_next = (nsamp_reg == '0) ? ST_DRAIN : ST_RUN;
            cnt_next   = '0;
         end else cnt_next = cnt_reg + 16'd1;
         ST_RUN: if (pushed_reg == nsamp_reg) begin
            state_next = ST_DRAIN;
            cnt_next   = '0;
         end else if (!fifo_empty) begin
            fifo_pop         = 1'b1;
            pushed_next      = pushed_reg + 24'd1;
            c_push_samp_next = 1'b1;
            c_samp_next      = fifo_head;
         end
         // The drain entry cycle is followed by DRAIN_CYC full wait cycles before DONE.
         ST_DRAIN: if (cnt_reg == 16'(DRAIN_CYC)) begin
            state_next = ST_DONE;
         end else cnt_next = cnt_reg + 16'd1;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase

      if (abort) begin
         state_next       = ST_IDLE;
         fifo_pop         = 1'b0;
         load_en          = 1'b0;
         c_push_samp_next = 1'b0;
         c_samp_next      = '0;
      end

      corr_next = corr_reg;
      if (state_reg == ST_IDLE) begin
         if (start && !abort) corr_next = '0;
      end else if (bus.c_push_corr && corr_reg != '1) begin
         corr_next = corr_reg + 24'd1;
      end

      level_next = fifo_flush ? '0 : fifo_level + LW'(fifo_push) - LW'(fifo_pop);

      c_strobe_next = load_en;
      c_addr_next   = load_en ? load_idx : '0;
      // A config write landing with the accepted start must reach the first LOAD beat.
      if (!load_en)                                   c_din_next = '0;
      else if (bank_we && bus.cfg_addr == load_idx)   c_din_next = bus.cfg_wdata;
      else                                            c_din_next = bank_reg[load_idx];

      c_sync_next  = (state_next == ST_SYNC);
      s_ready_next = (state_next == ST_SYNC || state_next == ST_POST || state_next == ST_RUN)
                     && (level_next < LW'(FIFO_DEPTH)) && (acc_next < nsamp_next);
      busy_next    = (state_next != ST_IDLE);
      done_next    = (state_next == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         nsamp_reg       <= '0;
         acc_reg         <= '0;
         pushed_reg      <= '0;
         corr_reg        <= '0;
         s_ready_reg     <= 1'b0;
         c_din_reg       <= '0;
         c_addr_reg      <= '0;
         c_strobe_reg    <= 1'b0;
         c_samp_reg      <= '0;
         c_push_samp_reg <= 1'b0;
         c_sync_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         nsamp_reg       <= nsamp_next;
         acc_reg         <= acc_next;
         pushed_reg      <= pushed_next;
         corr_reg        <= corr_next;
         s_ready_reg     <= s_ready_next;
         c_din_reg       <= c_din_next;
         c_addr_reg      <= c_addr_next;
         c_strobe_reg    <= c_strobe_next;
         c_samp_reg      <= c_samp_next;
         c_push_samp_reg <= c_push_samp_next;
         c_sync_reg      <= c_sync_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   assign bus.s_ready     = s_ready_reg;
   assign bus.c_din       = c_din_reg;
   assign bus.c_addr      = c_addr_reg;
   assign bus.c_strobe    = c_strobe_reg;
   assign bus.c_samp      = c_samp_reg;
   assign bus.c_push_samp = c_push_samp_reg;
   assign bus.c_sync      = c_sync_reg;
   assign busy            = busy_reg;
   assign done            = done_reg;
   assign corr_cnt        = corr_reg;
endmodule

// File: tb/tb_ss_seq.sv
// Randomised bench for ss_seq against a queue/arithmetic reference of the run schedule.
module tb_ss_seq;
   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort;
   logic [23:0] nsamp;
   logic        busy, done;
   logic [23:0] corr_cnt;

   ss_seq_if bus();

   ss_seq dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .nsamp    (nsamp),
      .busy     (busy),
      .done     (done),
      .corr_cnt (corr_cnt),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0] bank_model [16];
   logic [11:0] src [$];
   int          src_pos   = 0;
   int          cur_nsamp = 0;
   bit          gaps_en   = 0;
   bit          xfer_seen = 0;
   bit          ready_late = 0;

   int          st_cyc [$];
   logic [3:0]  st_addr [$];
   logic [31:0] st_din [$];
   int          sy_cyc [$];
   int          ps_cyc [$];
   logic [11:0] ps_val [$];
   int          dn_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.c_strobe) begin
         st_cyc.push_back(cyc); st_addr.push_back(bus.c_addr); st_din.push_back(bus.c_din);
      end
      if (bus.c_sync) sy_cyc.push_back(cyc);
      if (bus.c_push_samp) begin
         ps_cyc.push_back(cyc); ps_val.push_back(bus.c_samp);
      end
      if (done) dn_cyc.push_back(cyc);
      if (bus.s_ready && src_pos >= cur_nsamp) ready_late = 1;
      xfer_seen = bus.s_valid && bus.s_ready;
   end

   // Upstream source: presents src[] in order, optionally with 1-3 cycle gaps.
   initial begin
      int gap_cnt;
      gap_cnt = 0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (xfer_seen) src_pos++;
         if (gap_cnt > 0) begin
            bus.s_valid = 1'b0; gap_cnt--;
         end else if (src_pos < src.size()) begin
            if (gaps_en && $urandom_range(0, 99) < 20) begin
               bus.s_valid = 1'b0; gap_cnt = $urandom_range(0, 2);
            end else begin
               bus.s_valid = 1'b1; bus.s_data = src[src_pos];
            end
         end else bus.s_valid = 1'b0;
      end
   end

   task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic begin_run(int n, output int t);
      st_cyc.delete(); st_addr.delete(); st_din.delete(); sy_cyc.delete();
      ps_cyc.delete(); ps_val.delete(); dn_cyc.delete();
      src_pos = 0; cur_nsamp = n; ready_late = 0;
      nsamp = 24'(n); start = 1'b1; t = cyc;
      tick();
      start = 1'b0; bus.cfg_we = 1'b0;
      $display("run start T=%0d nsamp=%0d", t, n);
   endtask

   task automatic wait_done(int budget, output int dc);
      int k = 0;
      while (dn_cyc.size() == 0 && k < budget) begin tick(); k++; end
      if (dn_cyc.size() == 0) begin
         check_val("done_timeout", 0, 1); dc = -1;
      end else dc = dn_cyc[0];
      tick(2);
   endtask

   task automatic wait_pushes(int n, int budget);
      int k = 0;
      while (ps_val.size() < n && k < budget) begin tick(); k++; end
      if (ps_val.size() < n) check_val("push_timeout", 64'(ps_val.size()), 64'(n));
   endtask

   task automatic cfg_write(int a, logic [31:0] d);
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_wdata = d;
      tick();
      bus.cfg_we = 1'b0;
      bank_model[a] = d;
      $display("cfg write addr=%0d data=%08h", a, d);
   endtask

   // Expected LOAD: beat k on cycle t+1+k, address k, data from the host bank model.
   task automatic check_load(int t);
      check_val("load_beats", 64'(st_cyc.size()), 16);
      for (int i = 0; i < 16 && i < st_cyc.size(); i++) begin
         check_val($sformatf("load_cyc%0d", i), 64'(st_cyc[i]), 64'(t + 1 + i));
         check_val($sformatf("load_addr%0d", i), 64'(st_addr[i]), 64'(i));
         check_val($sformatf("load_din%0d", i), 64'(st_din[i]), 64'(bank_model[i]));
      end
   endtask

   task automatic check_all_zero(string pfx);
      check_val({pfx, "_busy"}, 64'(busy), 0);
      check_val({pfx, "_done"}, 64'(done), 0);
      check_val({pfx, "_corr"}, 64'(corr_cnt), 0);
      check_val({pfx, "_s_ready"}, 64'(bus.s_ready), 0);
      check_val({pfx, "_strobe"}, 64'(bus.c_strobe), 0);
      check_val({pfx, "_sync"}, 64'(bus.c_sync), 0);
      check_val({pfx, "_push_samp"}, 64'(bus.c_push_samp), 0);
      check_val({pfx, "_samp"}, 64'(bus.c_samp), 0);
      check_val({pfx, "_din"}, 64'(bus.c_din), 0);
      check_val({pfx, "_addr"}, 64'(bus.c_addr), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, dc;
      reset = 1'b0; start = 1'b0; abort = 1'b0; nsamp = '0;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.c_push_corr = 1'b0;
      for (int i = 0; i < 16; i++) bank_model[i] = '0;
      tick(3);
      check_all_zero("rst");
      reset = 1'b1;
      tick(2);

      // Load pattern, nsamp=0; addr 0 written in the start cycle itself.
      for (int k = 1; k < 16; k++) cfg_write(k, 32'hA500_0000 + 32'(k));
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_wdata = 32'hA500_0000;
      bank_model[0] = 32'hA500_0000;
      begin_run(0, t);
      wait_done(800, dc);
      check_load(t);
      check_val("sync_len", 64'(sy_cyc.size()), 2);
      if (sy_cyc.size() == 2) begin
         check_val("sync_first", 64'(sy_cyc[0]), 64'(t + 19));
         check_val("sync_last", 64'(sy_cyc[1]), 64'(t + 20));
      end
      check_val("done0_cyc", 64'(dc), 64'(t + 525));
      check_val("done0_pulses", 64'(dn_cyc.size()), 1);
      check_val("nsamp0_pushes", 64'(ps_val.size()), 0);
      check_val("nsamp0_corr", 64'(corr_cnt), 0);
      check_val("nsamp0_busy_after", 64'(busy), 0);

      // Eight back-to-back samples, then three correlator pushes while draining.
      src.delete();
      for (int i = 1; i <= 8; i++) src.push_back(12'(i));
      gaps_en = 0;
      begin_run(8, t);
      wait_pushes(8, 200);
      tick(5);
      repeat (3) begin
         bus.c_push_corr = 1'b1; tick(); bus.c_push_corr = 1'b0; tick(2);
      end
      wait_done(800, dc);
      check_val("n8_pushes", 64'(ps_val.size()), 8);
      for (int i = 0; i < 8 && i < ps_val.size(); i++) begin
         check_val($sformatf("n8_val%0d", i), 64'(ps_val[i]), 64'(i + 1));
         check_val($sformatf("n8_consec%0d", i), 64'(ps_cyc[i]), 64'(ps_cyc[0] + i));
      end
      if (ps_cyc.size() > 0) check_val("n8_after_post", 64'(ps_cyc[0] >= t + 24), 1);
      check_val("n8_accepted", 64'(src_pos), 8);
      check_val("n8_ready_late", 64'(ready_late), 0);
      check_val("n8_corr_done", 64'(corr_cnt), 3);
      bus.c_push_corr = 1'b1; tick(); bus.c_push_corr = 1'b0; tick(2);
      check_val("idle_corr_hold", 64'(corr_cnt), 3);

      // 100 random samples with upstream gaps; a stray start and cfg write mid-run.
      src.delete();
      for (int i = 0; i < 100; i++) src.push_back(12'($urandom));
      gaps_en = 1;
      begin_run(100, t);
      check_val("corr_clear_on_start", 64'(corr_cnt), 0);
      wait_pushes(50, 2000);
      start = 1'b1; nsamp = 24'd5;
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'd3; bus.cfg_wdata = 32'hDEAD_BEEF;
      tick();
      start = 1'b0; bus.cfg_we = 1'b0;
      wait_done(3000, dc);
      check_val("n100_pushes", 64'(ps_val.size()), 100);
      for (int i = 0; i < 100 && i < ps_val.size(); i++) begin
         if (ps_val[i] !== src[i]) check_val($sformatf("n100_val%0d", i), 64'(ps_val[i]), 64'(src[i]));
         if (ps_cyc[i] < t + 24 || ps_cyc[i] >= dc) check_val($sformatf("n100_window%0d", i), 64'(ps_cyc[i]), 64'(dc));
      end
      check_val("n100_order_ok", 64'(ps_val.size() == 100 && ps_val == src), 1);
      check_val("n100_single_load", 64'(st_cyc.size()), 16);
      check_val("n100_single_done", 64'(dn_cyc.size()), 1);
      check_val("n100_accepted", 64'(src_pos), 100);
      check_val("n100_ready_late", 64'(ready_late), 0);
      gaps_en = 0;

      // Abort the cycle after LOAD beat 5; then a fresh config write and full reload.
      src.delete();
      begin_run(4, t);
      tick(6);
      abort = 1'b1; tick(); abort = 1'b0;
      check_val("abort_strobe", 64'(bus.c_strobe), 0);
      check_val("abort_busy", 64'(busy), 0);
      check_val("abort_beats", 64'(st_cyc.size()), 7);
      tick(40);
      check_val("abort_no_done", 64'(dn_cyc.size()), 0);
      cfg_write(2, 32'h1234_5678);
      begin_run(0, t);
      wait_done(800, dc);
      check_load(t);
      check_val("reload_done_cyc", 64'(dc), 64'(t + 525));

      // Asynchronous reset in the middle of RUN.
      src.delete();
      for (int i = 0; i < 40; i++) src.push_back(12'($urandom));
      begin_run(40, t);
      wait_pushes(3, 200);
      @(negedge clk); #2;
      check_val("pre_reset_busy", 64'(busy), 1);
      reset = 1'b0;
      #1;
      check_all_zero("async_rst");
      src.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 16; i++) bank_model[i] = '0;
      tick(2);
      begin_run(0, t);
      wait_done(800, dc);
      check_load(t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Sequencer for the spread spectrum correlator (ss).
- Loads the correlator's 16-entry register file from a host-written shadow bank.
- Issues the sync burst with the correlator's required guard gaps.
- Streams a programmed number of 12-bit samples from an upstream valid/ready source into the correlator, then runs a drain window, counting correlator result pushes.
- Sits between the host/sample source and the ss instance; drives all ss control inputs.

Parameters:
NREGS, 16, number of correlator registers loaded per run (addr 0..NREGS-1)
FIFO_DEPTH, 4, sample skid FIFO depth (power of 2)
SYNC_PRE, 2, idle cycles before sync
SYNC_HI, 2, cycles sync is held high
SYNC_POST, 3, idle cycles after sync before first sample
DRAIN_CYC, 500, cycles waited after last sample before done

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous active-low reset (reset=0 resets)
cfg_we  in  1  shadow-bank write strobe
cfg_addr  in  4  shadow-bank write address
cfg_wdata  in  32  shadow-bank write data
start  in  1  begin a run; ignored unless IDLE
abort  in  1  terminate run, return to IDLE
nsamp  in  24  samples in the run, captured on accepted start
s_valid  in  1  upstream sample valid
s_data  in  12  upstream sample
s_ready  out  1  upstream sample ready
c_din  out  32  to ss din
c_addr  out  4  to ss addr
c_strobe  out  1  to ss strobe
c_samp  out  12  to ss samp
c_push_samp  out  1  to ss push_samp
c_sync  out  1  to ss sync
c_push_corr  in  1  from ss push_corr
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
corr_cnt  out  24  correlator pushes counted in the current run

Behaviour:
- All outputs are registered; they change only just after a clk rise, which meets the correlator's hold requirement.
- Reset values:
  - all outputs 0
  - state IDLE, FIFO empty
  - shadow bank all 0
- Shadow bank:
  - cfg_we writes cfg_wdata to entry cfg_addr in IDLE only; writes in other states are dropped.
  - A write in the same cycle as an accepted start is used by the run.
- State sequence (start accepted at cycle T):
  - IDLE: start=1 and abort=0 -> LOAD. Latch nsamp, clear corr_cnt.
  - LOAD: cycles T+1..T+NREGS. c_strobe=1, c_addr=k, c_din=bank[k] for k=0..NREGS-1 in order. Outside LOAD, c_strobe=0, c_addr=0, c_din=0.
  - PRE: SYNC_PRE cycles, all controls low.
  - SYNC: c_sync=1 for SYNC_HI cycles.
  - POST: SYNC_POST cycles, c_sync=0.
  - RUN: entered at T+NREGS+SYNC_PRE+SYNC_HI+SYNC_POST+1 (T+24 with defaults).
  - DRAIN: DRAIN_CYC cycles.
  - DONE: done=1 for one cycle, then IDLE.
- s_ready = (state in SYNC, POST or RUN) and FIFO not full and accepted-count < nsamp. A transfer occurs when s_valid and s_ready are both high.
- RUN push:
  - Each cycle the FIFO is non-empty: pop, c_push_samp=1, c_samp=head.
  - Upstream gaps give c_push_samp=0. No other back-pressure toward the ss.
  - When pushed-count reaches nsamp, go to DRAIN on the next cycle.
- nsamp=0: POST goes directly to DRAIN; no samples are accepted.
- corr_cnt increments on each c_push_corr=1 in any non-IDLE state and saturates at 2^24-1. It holds its value in IDLE until the next accepted start.
- abort=1 in any state: next state IDLE, FIFO flushed, all c_* outputs 0, no done pulse. corr_cnt holds. abort wins over start in the same cycle.
- start while busy is ignored.
- FIFO:
  - Simultaneous push and pop when full is not possible, since s_ready is low when full.
  - Simultaneous push and pop when empty: the pushed sample is popped on a later cycle, not bypassed.
  - Pointers wrap modulo FIFO_DEPTH.
- reset asserted mid-run: everything returns to reset values immediately (asynchronous).

Decomposition:
- ss_seq_pkg: state enum (IDLE, LOAD, PRE, SYNC, POST, RUN, DRAIN, DONE), NREGS/guard-cycle default constants, 24-bit count typedef.
- One sub-module, ss_samp_fifo: parameterised 12-bit synchronous FIFO with push, pop, flush, full and empty.

Test Plan:
- Write bank[k]=32'hA5000000+k, start with nsamp=0 at T -> c_strobe high T+1..T+16 with addr 0..15 and matching data, c_sync high T+19..T+20, done at T+24+500+1, corr_cnt=0.
- nsamp=8, s_valid always 1, samples 12'h001..12'h008 -> c_push_samp high on 8 consecutive RUN cycles with samples in order, s_ready low after the 8th accept.
- Upstream random gaps (s_valid low 1-3 cycles, ~20% of cycles), nsamp=100 -> exactly 100 pushes, order preserved, no push outside RUN.
- Drive c_push_corr 3 times during DRAIN and once in IDLE -> corr_cnt=3 after done; holds 3 until next start.
- Abort in the cycle after LOAD addr 5 -> next cycle c_strobe=0, busy=0, no done pulse. cfg write then accepted; a new start reloads from addr 0.
- Start during RUN, and cfg_we during RUN -> both ignored (bank content unchanged, sequence unaffected). Reset pulse mid-RUN -> all outputs 0 without waiting for a clk edge.
